// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci/Galois LFSR random source with seed load, valid/ready
// draw handshake, all-zero lockup recovery and return-to-seed marker.
module lfsr_prng #(
  parameter int          DW_PRNG  = 16,
  parameter logic [31:0] TAPS     = 32'h0000_B400,
  parameter int          MODE     = 0,
  parameter int          STEP     = 1,
  parameter logic [31:0] DEF_SEED = 32'h0000_0001
) (
  input  logic               i_clk_prng,
  input  logic               i_rst_prng,
  input  logic               i_load_prng,
  input  logic [DW_PRNG-1:0] i_seed_prng,
  input  logic               i_ready_prng,
  output logic               o_valid_prng,
  output logic [DW_PRNG-1:0] o_rnd_prng,
  output logic               o_lock_prng,
  output logic               o_hit_prng
);

  localparam logic [DW_PRNG-1:0] TAPS_M = TAPS[DW_PRNG-1:0];
  localparam logic [DW_PRNG-1:0] SEED_M = DEF_SEED[DW_PRNG-1:0];

  logic [DW_PRNG-1:0] state_q, state_d;
  logic [DW_PRNG-1:0] seed_q, seed_d;
  logic               valid_q, valid_d;
  logic               lock_q, lock_d;
  logic               hit_q, hit_d;

  logic [DW_PRNG-1:0] stepped;
  logic [DW_PRNG-1:0] drawn;
  logic [DW_PRNG-1:0] seed_in;
  logic               zero_step;
  logic               draw;

  function automatic logic [DW_PRNG-1:0] step1(input logic [DW_PRNG-1:0] s);
    logic [DW_PRNG-1:0] r;
    if (MODE == 0) begin
      r = {s[DW_PRNG-2:0], ^(s & TAPS_M)};
    end else begin
      r = (s >> 1) ^ (s[0] ? TAPS_M : '0);
    end
    return r;
  endfunction

  // STEP single steps unrolled into one combinational cone.
  always_comb begin
    stepped = state_q;
    for (int k = 0; k < STEP; k++) begin
      stepped = step1(stepped);
    end
  end

  // A zero intermediate stays zero under both structures, so testing the final value suffices.
  assign zero_step = (stepped == '0);
  assign drawn     = zero_step ? SEED_M : stepped;
  assign seed_in   = (i_seed_prng == '0) ? SEED_M : i_seed_prng;
  assign draw      = valid_q & i_ready_prng & ~i_load_prng;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    valid_d = 1'b1;
    lock_d  = 1'b0;
    hit_d   = 1'b0;
    if (i_load_prng) begin
      state_d = seed_in;
      seed_d  = seed_in;
      valid_d = 1'b0;
      lock_d  = (i_seed_prng == '0);
    end else if (draw) begin
      state_d = drawn;
      lock_d  = zero_step;
      hit_d   = (drawn == seed_q);
    end
  end

  always_ff @(posedge i_clk_prng) begin
    if (i_rst_prng) begin
      state_q <= SEED_M;
      seed_q  <= SEED_M;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      hit_q   <= hit_d;
    end
  end

  assign o_valid_prng = valid_q;
  assign o_rnd_prng   = state_q;
  assign o_lock_prng  = lock_q;
  assign o_hit_prng   = hit_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench: four lfsr_prng configurations on shared stimulus, checked each cycle
// against a polynomial-rule model plus hand-computed literal expectations.
module tb_lfsr_prng;

  localparam int          CFG_DW   [4] = '{16, 16, 4, 16};
  localparam logic [31:0] CFG_TAPS [4] = '{32'hB400, 32'hB400, 32'hC, 32'hB400};
  localparam int          CFG_MODE [4] = '{1, 0, 0, 1};
  localparam int          CFG_STEP [4] = '{1, 1, 1, 2};

  logic        clk;
  logic        rst;
  logic        load;
  logic        ready;
  logic [15:0] seed;

  logic [15:0] rnd0, rnd1, rnd3;
  logic [3:0]  rnd2;
  logic        valid0, valid1, valid2, valid3;
  logic        lock0, lock1, lock2, lock3;
  logic        hit0, hit1, hit2, hit3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lfsr_prng #(.DW_PRNG(16), .TAPS(CFG_TAPS[0]), .MODE(1), .STEP(1), .DEF_SEED(32'h1)) u_gal (
    .i_clk_prng(clk), .i_rst_prng(rst), .i_load_prng(load), .i_seed_prng(seed),
    .i_ready_prng(ready), .o_valid_prng(valid0), .o_rnd_prng(rnd0),
    .o_lock_prng(lock0), .o_hit_prng(hit0));

  lfsr_prng #(.DW_PRNG(16), .TAPS(CFG_TAPS[1]), .MODE(0), .STEP(1), .DEF_SEED(32'h1)) u_fib (
    .i_clk_prng(clk), .i_rst_prng(rst), .i_load_prng(load), .i_seed_prng(seed),
    .i_ready_prng(ready), .o_valid_prng(valid1), .o_rnd_prng(rnd1),
    .o_lock_prng(lock1), .o_hit_prng(hit1));

  lfsr_prng #(.DW_PRNG(4), .TAPS(CFG_TAPS[2]), .MODE(0), .STEP(1), .DEF_SEED(32'h1)) u_fib4 (
    .i_clk_prng(clk), .i_rst_prng(rst), .i_load_prng(load), .i_seed_prng(seed[3:0]),
    .i_ready_prng(ready), .o_valid_prng(valid2), .o_rnd_prng(rnd2),
    .o_lock_prng(lock2), .o_hit_prng(hit2));

  lfsr_prng #(.DW_PRNG(16), .TAPS(CFG_TAPS[3]), .MODE(1), .STEP(2), .DEF_SEED(32'h1)) u_gal2 (
    .i_clk_prng(clk), .i_rst_prng(rst), .i_load_prng(load), .i_seed_prng(seed),
    .i_ready_prng(ready), .o_valid_prng(valid3), .o_rnd_prng(rnd3),
    .o_lock_prng(lock3), .o_hit_prng(hit3));

  logic [31:0] d_rnd   [4];
  logic        d_valid [4];
  logic        d_lock  [4];
  logic        d_hit   [4];

  assign d_rnd[0] = {16'b0, rnd0};
  assign d_rnd[1] = {16'b0, rnd1};
  assign d_rnd[2] = {28'b0, rnd2};
  assign d_rnd[3] = {16'b0, rnd3};
  assign d_valid[0] = valid0; assign d_valid[1] = valid1;
  assign d_valid[2] = valid2; assign d_valid[3] = valid3;
  assign d_lock[0] = lock0;   assign d_lock[1] = lock1;
  assign d_lock[2] = lock2;   assign d_lock[3] = lock3;
  assign d_hit[0] = hit0;     assign d_hit[1] = hit1;
  assign d_hit[2] = hit2;     assign d_hit[3] = hit3;

  // Reference: polynomial rules on plain integers.
  function automatic logic [31:0] mask_of(int dw);
    return (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
  endfunction

  function automatic logic [31:0] advance(int i, logic [31:0] s);
    logic [31:0] m;
    logic [31:0] t;
    logic [31:0] r;
    logic [31:0] fb;
    m = mask_of(CFG_DW[i]);
    t = CFG_TAPS[i] & m;
    r = s & m;
    for (int k = 0; k < CFG_STEP[i]; k++) begin
      if (CFG_MODE[i] == 0) begin
        fb = 32'($countones(r & t) % 2);
        r  = ((r << 1) | fb) & m;
      end else begin
        r = (r >> 1) ^ (r[0] ? t : 32'd0);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] drawn_of(int i, logic [31:0] s);
    logic [31:0] r;
    r = advance(i, s);
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

  function automatic logic [31:0] loaded_of(int i, logic [15:0] sd);
    logic [31:0] v;
    v = {16'b0, sd} & mask_of(CFG_DW[i]);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  logic [31:0] m_state [4];
  logic [31:0] m_seed  [4];
  logic        m_valid [4];
  logic        m_lock  [4];
  logic        m_hit   [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_state[i] <= 32'd1;
        m_seed[i]  <= 32'd1;
        m_valid[i] <= 1'b0;
        m_lock[i]  <= 1'b0;
        m_hit[i]   <= 1'b0;
      end else if (load) begin
        m_state[i] <= loaded_of(i, seed);
        m_seed[i]  <= loaded_of(i, seed);
        m_valid[i] <= 1'b0;
        m_lock[i]  <= (({16'b0, seed} & mask_of(CFG_DW[i])) == 32'd0);
        m_hit[i]   <= 1'b0;
      end else if (m_valid[i] && ready) begin
        m_state[i] <= drawn_of(i, m_state[i]);
        m_valid[i] <= 1'b1;
        m_lock[i]  <= (advance(i, m_state[i]) == 32'd0);
        m_hit[i]   <= (drawn_of(i, m_state[i]) == m_seed[i]);
      end else begin
        m_valid[i] <= 1'b1;
        m_lock[i]  <= 1'b0;
        m_hit[i]   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (d_rnd[i] !== m_state[i] || d_valid[i] !== m_valid[i] ||
            d_lock[i] !== m_lock[i] || d_hit[i] !== m_hit[i]) begin
          errors++;
          $display("FAIL model_inst%0d rnd/valid/lock/hit actual=%h/%b/%b/%b required=%h/%b/%b/%b",
                   i, d_rnd[i], d_valid[i], d_lock[i], d_hit[i],
                   m_state[i], m_valid[i], m_lock[i], m_hit[i]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  bit [15:0] seen;
  int        n_hit;
  int        n_seen;

  initial begin
    rst = 1'b1; load = 1'b0; ready = 1'b0; seed = 16'h0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset_rnd", d_rnd[0], 32'h1);
    chk("reset_valid", {31'b0, valid0}, 32'h0);
    chk("reset_flags", {30'b0, lock0, hit0}, 32'h0);

    rst = 1'b0;
    cyc();
    chk("valid_after_reset", {31'b0, valid0}, 32'h1);

    // Galois single step from ACE1
    load = 1'b1; seed = 16'hACE1;
    cyc();
    chk("gal_load_rnd", d_rnd[0], 32'hACE1);
    chk("gal_load_valid", {31'b0, valid0}, 32'h0);
    load = 1'b0; ready = 1'b1;
    cyc();
    chk("gal_hold_rnd", d_rnd[0], 32'hACE1);
    chk("gal_hold_valid", {31'b0, valid0}, 32'h1);
    cyc();
    chk("gal_draw1", d_rnd[0], 32'hE270);
    cyc();
    chk("gal_draw2", d_rnd[0], 32'h7138);

    // Fibonacci single draw then hold; STEP=2 Galois in parallel
    ready = 1'b0; load = 1'b1; seed = 16'hACE1;
    cyc();
    load = 1'b0;
    cyc();
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("fib_draw", d_rnd[1], 32'h59C3);
    chk("gal2_draw", d_rnd[3], 32'h7138);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("fib_hold", d_rnd[1], 32'h59C3);
    end

    // Load wins over a simultaneous accept
    load = 1'b1; ready = 1'b1; seed = 16'h1234;
    cyc();
    chk("load_ready_rnd", d_rnd[3], 32'h1234);
    chk("load_ready_hit", {31'b0, hit3}, 32'h0);
    load = 1'b0; ready = 1'b0;

    // 4-bit maximal sequence: period 15 with one hit
    load = 1'b1; seed = 16'h0001;
    cyc();
    load = 1'b0; ready = 1'b1;
    cyc();
    seen = '0; n_hit = 0; n_seen = 0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (!seen[rnd2]) n_seen++;
      seen[rnd2] = 1'b1;
      if (hit2) n_hit++;
    end
    chk("p15_last_rnd", d_rnd[2], 32'h1);
    chk("p15_last_hit", {31'b0, hit2}, 32'h1);
    chk("p15_distinct", 32'(n_seen), 32'd15);
    chk("p15_zero_unseen", {31'b0, seen[0]}, 32'h0);
    chk("p15_hit_count", 32'(n_hit), 32'd1);
    ready = 1'b0;
    cyc();
    chk("p15_hit_pulse_end", {31'b0, hit2}, 32'h0);

    // Zero seed substitution
    load = 1'b1; seed = 16'h0000;
    cyc();
    load = 1'b0;
    chk("zero_seed_rnd", d_rnd[0], 32'h1);
    chk("zero_seed_lock", {31'b0, lock0}, 32'h1);
    chk("zero_seed_valid", {31'b0, valid0}, 32'h0);
    cyc();
    chk("zero_seed_lock_end", {31'b0, lock0}, 32'h0);
    chk("zero_seed_valid_back", {31'b0, valid0}, 32'h1);

    // Randomized phase, model-checked every cycle
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 15) == 0);
      ready = ($urandom_range(0, 3) != 0);
      seed  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      cyc();
    end
    rst = 1'b0; load = 1'b0;

    // Reset mid-stream with ready high
    load = 1'b1; seed = 16'hBEEF;
    cyc();
    load = 1'b0; ready = 1'b1;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_rnd", d_rnd[0], 32'h1);
    chk("midrst_rnd4", d_rnd[2], 32'h1);
    chk("midrst_valid", {31'b0, valid0}, 32'h0);
    chk("midrst_flags", {30'b0, lock0, hit0}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("midrst_valid_back", {31'b0, valid0}, 32'h1);
    chk("midrst_no_step", d_rnd[0], 32'h1);
    cyc();
    ready = 1'b0;
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
